// File: rtl/mc_ctrl_pkg.sv
// Shared state, opcode and mux-select encodings for the multicycle controller.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        JAL,
        TRAP
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_branch_cond.sv
// Branch resolution from funct3 and the ALU compare flags.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       Lt,
    output logic       taken
);

    // Select the flag test named by funct3; unsupported encodings never branch.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = Lt;
            3'b101:  taken = ~Lt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences the shared ALU and unified memory.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       InstrDone,
    output logic       Illegal
);

    statetype state, next;
    logic     taken;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .Zero   (Zero),
        .Lt     (Lt),
        .taken  (taken)
    );

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    // Next-state and output decode; strobes are masked while reset is high
    // because FETCH itself drives IRWrite/PCWrite from MemReady.
    always_comb begin
        next      = state;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        RegWrite  = 1'b0;
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) next = DECODE;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXECUTER;
                    OP_I:         next = EXECUTEI;
                    OP_B:         next = BRANCH;
                    OP_JAL:       next = JAL;
                    default:      next = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                next    = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) next = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                next      = FETCH;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
                if (MemReady) next = FETCH;
            end
            EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
                next    = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                next    = ALUWB;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                next      = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUOp     = ALUOP_SUB;
                PCWrite   = taken;
                InstrDone = 1'b1;
                next      = FETCH;
            end
            JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                next    = ALUWB;
            end
            TRAP: begin
                Illegal = 1'b1;
                next    = TRAP;
            end
            default: next = FETCH;
        endcase
        if (reset) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            InstrDone = 1'b0;
            Illegal   = 1'b0;
        end
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_B:    ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the RISC-V core. It replaces the single-cycle main decoder with a state machine that sequences one shared ALU and one unified instruction/data memory over several cycles per instruction. It sits beside the ALU decoder, which still consumes `ALUOp`. It drives all datapath enables and muxes, and stalls on a memory-ready handshake.

## Interface
Parameters:
- None. State and mux encodings come from `mc_ctrl_pkg`.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-high reset
- `op`  input  7  opcode field of the instruction register
- `funct3`  input  3  funct3 field of the instruction register
- `Zero`  input  1  ALU result == 0
- `Lt`  input  1  ALU signed less-than (SrcA < SrcB)
- `MemReady`  input  1  memory completes the current access this cycle
- `PCWrite`  output  1  PC register enable
- `AdrSrc`  output  1  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite`  output  1  memory write request
- `IRWrite`  output  1  instruction register and OldPC enable
- `ResultSrc`  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  output  2  SrcA mux: 00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB`  output  2  SrcB mux: 00 = rs2, 01 = ImmExt, 10 = constant 4
- `ImmSrc`  output  2  immediate format
- `ALUOp`  output  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded
- `RegWrite`  output  1  register file write enable
- `InstrDone`  output  1  one-cycle pulse when an instruction retires
- `Illegal`  output  1  sticky flag: unimplemented opcode decoded

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, TRAP.
- Outputs are Moore-decoded from state, except the strobes gated by `MemReady` or the branch condition. All outputs not listed for a state are 0.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH until MemReady, then goes to DECODE.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, ALUOp=00 to precompute the branch target.
  - Next state by `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BRANCH; 1101111 → JAL; any other opcode → TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB when MemReady.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite is held until MemReady, then the FSM goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = taken, where taken is: beq (000) Zero; bne (001) !Zero; blt (100) Lt; bge (101) !Lt; any other funct3 → 0.
  - Goes to FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - Goes to ALUWB, which writes PC+4 to rd.
- TRAP:
  - Absorbing state; all strobes are 0.
  - Illegal=1 until reset.
- ImmSrc is combinational from `op`: lw/I-type 00, sw 01, branch 10, jal 11, otherwise 00.
- InstrDone pulses for one cycle on each exit to FETCH: from MEMWB, ALUWB, BRANCH, and MEMWRITE with MemReady.

## Timing
- While `reset` is high:
  - State is FETCH.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - InstrDone and Illegal are 0.
  - Mux outputs take their FETCH values.
- Reset asserted mid-instruction aborts it immediately and asynchronously; no strobe glitches high.
- Cycle counts with zero wait states:
  - lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4.
- Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle and holds all outputs stable.
- MemReady is ignored in every other state.

## Structure
- `mc_ctrl_pkg` holds:
  - the `statetype` enum;
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL);
  - mux-select localparams for ResultSrc, ALUSrcA and ALUSrcB.
- One sub-module, `branch_cond` (funct3, Zero, Lt → taken).
- The FSM state register, next-state logic and output decode live in `mc_controller`.

## Test plan
- Reset, then release with MemReady=1 and op=0110011 → FETCH, DECODE, EXECUTER, ALUWB. RegWrite=1 only in cycle 4, ALUOp=10 in cycle 3, InstrDone in cycle 4.
- lw (0000011) with MemReady=0 for 2 cycles in MEMREAD → 7 cycles total. AdrSrc=1 held, RegWrite with ResultSrc=01 exactly once.
- sw (0100011) with MemReady low for 3 cycles in MEMWRITE → MemWrite held high for 4 cycles, ImmSrc=01, RegWrite never set.
- BRANCH with funct3=001: Zero=1 → PCWrite=0; Zero=0 → PCWrite=1. With funct3=101 and Lt=0 → PCWrite=1.
- jal (1101111) → PCWrite=1 in JAL, RegWrite=1 with ResultSrc=00 in the following ALUWB, ImmSrc=11.
- op=1111111 → TRAP after DECODE, Illegal=1 sticky, no strobes asserted. Then assert reset mid-TRAP → Illegal=0 and FETCH within the same cycle.
